// File: rtl/cpu_alu_seq_pkg.sv
// cpu_alu_seq_pkg: opcode, FSM state and flag types shared by the execute unit.
// CPU_ALU_DIV_EN selects whether DIVU/REMU are iterative (divider present) or illegal.
package pkg_cpu_typedefs;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_SLT   = 4'd4,
      OP_SLTU  = 4'd5,
      OP_XOR   = 4'd6,
      OP_SLL   = 4'd7,
      OP_SRL   = 4'd8,
      OP_SRA   = 4'd9,
      OP_MUL   = 4'd10,
      OP_MULHU = 4'd11,
      OP_DIVU  = 4'd12,
      OP_REMU  = 4'd13
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } alu_state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   function automatic logic is_iter(input logic [3:0] op);
`ifdef CPU_ALU_DIV_EN
      return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
`else
      return op inside {OP_MUL, OP_MULHU};
`endif
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return op inside {OP_DIVU, OP_REMU};
   endfunction

endpackage

// File: rtl/cpu_alu_seq_muldiv.sv
// cpu_alu_muldiv: DATA_WIDTH-step shift-add multiplier and, with CPU_ALU_DIV_EN, restoring divider.
// prod_o is {hi, lo}: the product for multiply, {remainder, quotient} for divide.
module cpu_alu_muldiv
   import pkg_cpu_typedefs::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
`ifdef CPU_ALU_DIV_EN
   input  logic                      div_i,
`endif
   input  logic [DATA_WIDTH-1:0]     a_i,
   input  logic [DATA_WIDTH-1:0]     b_i,
   output logic                      done_o,
   output logic [2*DATA_WIDTH-1:0]   prod_o
);

   localparam int W   = DATA_WIDTH;
   localparam int SHW = $clog2(DATA_WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(W - 1);

   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, b_q;
   logic [W-1:0]   cur_hi, cur_lo, cur_b;
   logic [SHW-1:0] cnt_q;
   logic           busy_q, done_q;
   logic [W:0]     ms;
`ifdef CPU_ALU_DIV_EN
   logic           div_q, cur_div, ge;
   logic [W:0]     sh, dr;
`endif

   // The first step runs on the start edge itself, so W steps end one edge early.
   assign cur_hi = start_i ? '0 : hi_q;
   assign cur_lo = start_i ? a_i : lo_q;
   assign cur_b  = start_i ? b_i : b_q;
   assign ms     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);

`ifdef CPU_ALU_DIV_EN
   assign cur_div = start_i ? div_i : div_q;
   assign sh      = {cur_hi, cur_lo[W-1]};
   assign ge      = sh >= {1'b0, cur_b};
   assign dr      = ge ? sh - {1'b0, cur_b} : sh;

   always_comb begin
      hi_d = cur_div ? dr[W-1:0] : ms[W:1];
      lo_d = cur_div ? {cur_lo[W-2:0], ge} : {ms[0], cur_lo[W-1:1]};
   end
`else
   always_comb begin
      hi_d = ms[W:1];
      lo_d = {ms[0], cur_lo[W-1:1]};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef CPU_ALU_DIV_EN
         div_q  <= 1'b0;
`endif
      end else begin
         done_q <= busy_q && cnt_q == LAST;
         if (start_i || busy_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
         end
         if (start_i) begin
            b_q    <= b_i;
            cnt_q  <= SHW'(1);
            busy_q <= 1'b1;
`ifdef CPU_ALU_DIV_EN
            div_q  <= div_i;
`endif
         end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) busy_q <= 1'b0;
         end
      end
   end

   assign done_o = done_q;
   assign prod_o = {hi_q, lo_q};

endmodule

// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: valid/ready execute unit with single-cycle ALU ops and iterative MUL/MULHU/DIVU/REMU.
// CPU_ALU_DIV_EN builds the divider; without it DIVU/REMU return 0 with op_err set.
module cpu_alu_seq
   import pkg_cpu_typedefs::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            op_sel,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] alu_out,
   output logic                  z_flag,
   output logic                  n_flag,
   output logic                  c_flag,
   output logic                  v_flag,
   output logic                  op_err
);

   localparam int W   = DATA_WIDTH;
   localparam int SHW = $clog2(DATA_WIDTH);

   alu_state_e         state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [W-1:0]       res_q, res_d;
   alu_flags_t         flags_q, flags_d;
   logic               err_q, err_d;
   logic               accept, start, md_done;
   logic [2*W-1:0]     md_prod;
   logic [W-1:0]       md_res, sc_res;
   logic               sc_c, sc_v, sc_err;
   logic [W:0]         sum, dif;
   logic [SHW-1:0]     shamt;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? (is_iter(op_sel) ? BUSY : DONE) : IDLE;
         BUSY:    state_d = md_done ? DONE : BUSY;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = state_q == IDLE;
      out_valid = state_q == DONE;
      accept    = in_valid && in_ready;
      start     = accept && is_iter(op_sel);
   end

   cpu_alu_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
`ifdef CPU_ALU_DIV_EN
      .div_i   (is_div(op_sel)),
`endif
      .a_i     (in_a),
      .b_i     (in_b),
      .done_o  (md_done),
      .prod_o  (md_prod)
   );

   assign sum   = {1'b0, in_a} + {1'b0, in_b};
   assign dif   = {1'b0, in_a} - {1'b0, in_b};
   assign shamt = in_b[SHW-1:0];

   // Iterative opcodes also land in default here; their result comes from the muldiv unit.
   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_err = 1'b0;
      case (op_sel)
         OP_ADD: begin
            sc_res = sum[W-1:0];
            sc_c   = sum[W];
            sc_v   = (in_a[W-1] == in_b[W-1]) && (sum[W-1] != in_a[W-1]);
         end
         OP_SUB: begin
            sc_res = dif[W-1:0];
            sc_c   = dif[W];
            sc_v   = (in_a[W-1] != in_b[W-1]) && (dif[W-1] != in_a[W-1]);
         end
         OP_AND:  sc_res = in_a & in_b;
         OP_OR:   sc_res = in_a | in_b;
         OP_XOR:  sc_res = in_a ^ in_b;
         OP_SLT:  sc_res = {{(W-1){1'b0}}, $signed(in_a) < $signed(in_b)};
         OP_SLTU: sc_res = {{(W-1){1'b0}}, dif[W]};
         OP_SLL:  sc_res = in_a << shamt;
         OP_SRL:  sc_res = in_a >> shamt;
         OP_SRA:  sc_res = $unsigned($signed(in_a) >>> shamt);
         default: sc_err = 1'b1;
      endcase
   end

   assign md_res = (op_q == OP_MUL || op_q == OP_DIVU) ? md_prod[W-1:0] : md_prod[2*W-1:W];

   always_comb begin
      op_d    = op_q;
      res_d   = res_q;
      flags_d = flags_q;
      err_d   = err_q;
      if (accept) begin
         op_d = op_sel;
         if (!is_iter(op_sel)) begin
            res_d   = sc_res;
            flags_d = '{z: ~|sc_res, n: sc_res[W-1], c: sc_c, v: sc_v};
            err_d   = sc_err;
         end
      end else if (state_q == BUSY && md_done) begin
         res_d   = md_res;
         flags_d = '{z: ~|md_res, n: md_res[W-1], c: 1'b0, v: 1'b0};
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= '0;
         res_q   <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
      end else begin
         op_q    <= op_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         err_q   <= err_d;
      end
   end

   assign alu_out = res_q;
   assign z_flag  = flags_q.z;
   assign n_flag  = flags_q.n;
   assign c_flag  = flags_q.c;
   assign v_flag  = flags_q.v;
   assign op_err  = err_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// tb_cpu_alu_seq: directed vectors with hand-computed results for cpu_alu_seq at DATA_WIDTH=32.
// Expected DIVU/REMU results follow CPU_ALU_DIV_EN.
module tb_cpu_alu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op_sel = 4'd0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] alu_out;
   logic        z_flag, n_flag, c_flag, v_flag, op_err;

   int vec_cnt = 0;
   int err_cnt = 0;
   int lat;
   logic rdy_busy;

   localparam int LAT_ITER = 33;
`ifdef CPU_ALU_DIV_EN
   localparam int LAT_DIV = 33;
`else
   localparam int LAT_DIV = 1;
`endif

   cpu_alu_seq #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sel    (op_sel),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_out   (alu_out),
      .z_flag    (z_flag),
      .n_flag    (n_flag),
      .c_flag    (c_flag),
      .v_flag    (v_flag),
      .op_err    (op_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst) chk("excl", {31'd0, in_ready & out_valid}, 32'd0);

   // Issue one op; lat counts edges from the accept edge up to the first out_valid.
   task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      op_sel   = op;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 32'hDEAD_BEEF;
      in_b     = 32'h1234_5678;
      lat      = 1;
      rdy_busy = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_busy = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("idle", {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   task automatic vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res,
                      input logic [3:0] exp_zncv, input logic exp_err, input int exp_lat);
      run(op, a, b);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, alu_out, exp_res);
      chk({tag, "_zncv"}, {28'd0, z_flag, n_flag, c_flag, v_flag}, {28'd0, exp_zncv});
      chk({tag, "_err"}, {31'd0, op_err}, {31'd0, exp_err});
      chk({tag, "_rdy"}, {31'd0, rdy_busy}, 32'd0);
      drain();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_rdy", {31'd0, in_ready}, 32'd1);
      chk("rst_vld", {31'd0, out_valid}, 32'd0);
      chk("rst_out", alu_out, 32'd0);
      chk("rst_zncv", {28'd0, z_flag, n_flag, c_flag, v_flag}, 32'd0);
      chk("rst_err", {31'd0, op_err}, 32'd0);

      vec("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1010, 1'b0, 1);
      vec("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0101, 1'b0, 1);
      vec("sub_ovf",  4'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0001, 1'b0, 1);
      vec("sub_brw",  4'd1,  32'h1,         32'h2,         32'hFFFF_FFFF, 4'b0110, 1'b0, 1);
      vec("and",      4'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 1'b0, 1);
      vec("slt",      4'd4,  32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1'b0, 1);
      vec("sltu",     4'd5,  32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1000, 1'b0, 1);
      vec("xor",      4'd6,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 4'b0100, 1'b0, 1);
      vec("sll",      4'd7,  32'h1,         32'h24,        32'h10,        4'b0000, 1'b0, 1);
      vec("srl",      4'd8,  32'h8000_0000, 32'h1F,        32'h1,         4'b0000, 1'b0, 1);
      vec("sra",      4'd9,  32'h8000_0000, 32'h21,        32'hC000_0000, 4'b0100, 1'b0, 1);
      vec("mul",      4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0,         4'b1000, 1'b0, LAT_ITER);
      vec("mulhu",    4'd11, 32'h0001_0000, 32'h0001_0000, 32'h1,         4'b0000, 1'b0, LAT_ITER);
      vec("mul_big",  4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         4'b0000, 1'b0, LAT_ITER);
      vec("mulhu_big",4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100, 1'b0, LAT_ITER);
`ifdef CPU_ALU_DIV_EN
      vec("divu",     4'd12, 32'd100, 32'd7, 32'd14,        4'b0000, 1'b0, LAT_DIV);
      vec("remu",     4'd13, 32'd100, 32'd7, 32'd2,         4'b0000, 1'b0, LAT_DIV);
      vec("divu_0",   4'd12, 32'd7,   32'd0, 32'hFFFF_FFFF, 4'b0100, 1'b0, LAT_DIV);
      vec("remu_0",   4'd13, 32'd7,   32'd0, 32'd7,         4'b0000, 1'b0, LAT_DIV);
`else
      vec("divu",     4'd12, 32'd100, 32'd7, 32'd0, 4'b1000, 1'b1, LAT_DIV);
      vec("remu",     4'd13, 32'd100, 32'd7, 32'd0, 4'b1000, 1'b1, LAT_DIV);
      vec("divu_0",   4'd12, 32'd7,   32'd0, 32'd0, 4'b1000, 1'b1, LAT_DIV);
      vec("remu_0",   4'd13, 32'd7,   32'd0, 32'd0, 4'b1000, 1'b1, LAT_DIV);
`endif

      run(4'd3, 32'hF0, 32'h0F);
      chk("or_lat", 32'(lat), 32'd1);
      chk("or_res", alu_out, 32'hFF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_out", alu_out, 32'hFF);
         chk("hold_vld", {31'd0, out_valid}, 32'd1);
         chk("hold_rdy", {31'd0, in_ready}, 32'd0);
      end
      drain();

      op_sel   = 4'd12;
      in_a     = 32'd1000;
      in_b     = 32'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_out", alu_out, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("discard", {31'd0, out_valid}, 32'd0);

      vec("add_2_3", 4'd0,  32'd2, 32'd3, 32'd5, 4'b0000, 1'b0, 1);
      vec("ill15",   4'd15, 32'd9, 32'd4, 32'd0, 4'b1000, 1'b1, 1);
      vec("ill14",   4'd14, 32'd9, 32'd4, 32'd0, 4'b1000, 1'b1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
